dual_port_ram_arb: RTL and testbench



---
 rtl/dpram_pkg.sv | 16 +
 rtl/dual_port_ram_arb_rr_arb2.sv | 42 ++++
 rtl/dual_port_ram_arb.sv | 111 +++++++++++
 tb/tb_dual_port_ram_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// dpram_pkg
// Shared definitions for the dual-port arbitrated scratch RAM:
//   - default parameter widths (data, address, conflict counter)
//   - round-robin priority encoding (PRIO_A / PRIO_B)
package dpram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/dual_port_ram_arb_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter for same-address conflicts.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   hazard      : the two ports' addresses/opcodes collide (ignores req)
//   a_req/b_req : port requests
//   a_grant     : port A may proceed this cycle
//   b_grant     : port B may proceed this cycle
//   conflict    : both ports requesting into a hazard this cycle
// The priority pointer moves to the stalled port after every conflict,
// so a losing port waits at most one cycle.
module rr_arb2
  import dpram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hazard,
  input  logic a_req,
  input  logic b_req,
  output logic a_grant,
  output logic b_grant,
  output logic conflict
);

  prio_e prio;

  assign conflict = a_req && b_req && hazard;

  // Without a conflict both ports are granted; otherwise only the priority holder.
  assign a_grant = !conflict || (prio == PRIO_A);
  assign b_grant = !conflict || (prio == PRIO_B);

  // The loser of a conflict takes priority for the next conflict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prio <= PRIO_A;
    end else if (conflict) begin
      prio <= (prio == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

endmodule

// File: rtl/dual_port_ram_arb.sv
// dual_port_ram_arb
// True dual-port RAM with valid/ready handshakes per port and round-robin
// arbitration of same-address conflicts involving a write.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   a_req/b_req           : request valid
//   a_we/b_we             : 1 = write, 0 = read
//   a_addr/b_addr         : word address
//   a_wdata/b_wdata       : write data
//   a_ready/b_ready       : request accepted this cycle (combinational)
//   a_rvalid/b_rvalid     : registered read-data strobe
//   a_rdata/b_rdata       : registered read data (holds last value)
//   conflict_cnt          : saturating count of stall cycles
// Build option DPRAM_WRITE_FWD_EN: read-vs-write collisions are not
// arbitrated; the reader receives the writer's data (write-first). Only
// write-write collisions stall.
module dual_port_ram_arb
  import dpram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ready,
  output logic              b_ready,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic hazard, conflict, a_grant, b_grant, a_acc, b_acc;
  logic [DATA_W-1:0] a_rd_next, b_rd_next;

`ifdef DPRAM_WRITE_FWD_EN
  assign hazard = (a_addr == b_addr) && a_we && b_we;
`else
  assign hazard = (a_addr == b_addr) && (a_we || b_we);
`endif

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .hazard   (hazard),
    .a_req    (a_req),
    .b_req    (b_req),
    .a_grant  (a_grant),
    .b_grant  (b_grant),
    .conflict (conflict)
  );

  // Nothing is accepted while reset is asserted.
  assign a_ready = reset && a_grant;
  assign b_ready = reset && b_grant;
  assign a_acc   = a_req && a_ready;
  assign b_acc   = b_req && b_ready;

  // Arbitration guarantees two accepted writes never target the same word.
  always_ff @(posedge clk) begin
    if (a_acc && a_we) mem[a_addr] <= a_wdata;
    if (b_acc && b_we) mem[b_addr] <= b_wdata;
  end

  // Read data source; with forwarding a same-cycle write on the other port wins.
  always_comb begin
    a_rd_next = mem[a_addr];
    b_rd_next = mem[b_addr];
`ifdef DPRAM_WRITE_FWD_EN
    if (b_acc && b_we && (b_addr == a_addr)) a_rd_next = b_wdata;
    if (a_acc && a_we && (a_addr == b_addr)) b_rd_next = a_wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_acc && !a_we;
      b_rvalid <= b_acc && !b_we;
      if (a_acc && !a_we) a_rdata <= a_rd_next;
      if (b_acc && !b_we) b_rdata <= b_rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_port_ram_arb.sv
module tb_dual_port_ram_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, b_ready, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] conflict_cnt;

  int checks = 0;
  int fails  = 0;
  logic obs_ar, obs_br;

  always #5 clk = ~clk;

  dual_port_ram_arb dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .a_ready      (a_ready),
    .b_ready      (b_ready),
    .a_rvalid     (a_rvalid),
    .b_rvalid     (b_rvalid),
    .a_rdata      (a_rdata),
    .b_rdata      (b_rdata),
    .conflict_cnt (conflict_cnt)
  );

  // Drive one cycle of requests at the falling edge, capture ready just
  // after, then return 1 time unit after the rising edge.
  task automatic tick(input logic ar, input logic awe, input logic [3:0] aad, input logic [7:0] awd,
                      input logic br, input logic bwe, input logic [3:0] bad, input logic [7:0] bwd);
    @(negedge clk);
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
    obs_ar = a_ready;
    obs_br = b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(1, 0, 4'h3, 8'hFF, 1, 1, 4'h3, 8'hEE);
    checks++; if ({obs_ar, obs_br} !== 2'b00) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 00", {obs_ar, obs_br}); end
    checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin fails++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {a_rvalid, b_rvalid}); end
    checks++; if ({a_rdata, b_rdata} !== 16'h0000) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 0000", {a_rdata, b_rdata}); end
    checks++; if (conflict_cnt !== 8'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d expected 0", conflict_cnt); end
    reset = 1'b1;
    idle();
  endtask

  task automatic test_write_read();
    tick(1, 1, 4'h3, 8'h5A, 0, 0, 4'h0, 8'h00);
    checks++; if (obs_ar !== 1'b1) begin fails++; $display("[TB] FAIL wr_ready: got %b expected 1", obs_ar); end
    tick(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
    checks++; if (a_rvalid !== 1'b1) begin fails++; $display("[TB] FAIL rd_rvalid: got %b expected 1", a_rvalid); end
    checks++; if (a_rdata !== 8'h5A) begin fails++; $display("[TB] FAIL rd_data: got %h expected 5a", a_rdata); end
    idle();
    checks++; if (a_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rd_rvalid_drop: got %b expected 0", a_rvalid); end
    checks++; if (a_rdata !== 8'h5A) begin fails++; $display("[TB] FAIL rd_hold: got %h expected 5a", a_rdata); end
    checks++; if (conflict_cnt !== 8'd0) begin fails++; $display("[TB] FAIL wr_rd_cnt: got %0d expected 0", conflict_cnt); end
  endtask

  task automatic test_ww_conflict();
    tick(1, 1, 4'h7, 8'h11, 1, 1, 4'h7, 8'h22);
    checks++; if ({obs_ar, obs_br} !== 2'b10) begin fails++; $display("[TB] FAIL ww1_ready: got %b expected 10", {obs_ar, obs_br}); end
    checks++; if (conflict_cnt !== 8'd1) begin fails++; $display("[TB] FAIL ww1_cnt: got %0d expected 1", conflict_cnt); end
    tick(0, 0, 4'h0, 8'h00, 1, 1, 4'h7, 8'h22);
    checks++; if (obs_br !== 1'b1) begin fails++; $display("[TB] FAIL ww1_retry: got %b expected 1", obs_br); end
    tick(1, 0, 4'h7, 8'h00, 0, 0, 4'h0, 8'h00);
    checks++; if (a_rdata !== 8'h22) begin fails++; $display("[TB] FAIL ww1_mem: got %h expected 22", a_rdata); end
    tick(1, 1, 4'h7, 8'h11, 1, 1, 4'h7, 8'h22);
    checks++; if ({obs_ar, obs_br} !== 2'b01) begin fails++; $display("[TB] FAIL ww2_ready: got %b expected 01", {obs_ar, obs_br}); end
    tick(1, 1, 4'h7, 8'h11, 0, 0, 4'h0, 8'h00);
    checks++; if (obs_ar !== 1'b1) begin fails++; $display("[TB] FAIL ww2_retry: got %b expected 1", obs_ar); end
    checks++; if (conflict_cnt !== 8'd2) begin fails++; $display("[TB] FAIL ww2_cnt: got %0d expected 2", conflict_cnt); end
    tick(0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00);
    checks++; if (b_rdata !== 8'h11) begin fails++; $display("[TB] FAIL ww2_mem: got %h expected 11", b_rdata); end
  endtask

  task automatic test_rw_conflict();
    tick(1, 1, 4'h2, 8'h00, 0, 0, 4'h0, 8'h00);
    tick(1, 1, 4'h2, 8'h33, 1, 0, 4'h2, 8'h00);
`ifdef DPRAM_WRITE_FWD_EN
    checks++; if ({obs_ar, obs_br} !== 2'b11) begin fails++; $display("[TB] FAIL rw_ready: got %b expected 11", {obs_ar, obs_br}); end
    checks++; if (conflict_cnt !== 8'd2) begin fails++; $display("[TB] FAIL rw_cnt: got %0d expected 2", conflict_cnt); end
`else
    checks++; if ({obs_ar, obs_br} !== 2'b10) begin fails++; $display("[TB] FAIL rw_ready: got %b expected 10", {obs_ar, obs_br}); end
    checks++; if (conflict_cnt !== 8'd3) begin fails++; $display("[TB] FAIL rw_cnt: got %0d expected 3", conflict_cnt); end
    tick(0, 0, 4'h0, 8'h00, 1, 0, 4'h2, 8'h00);
    checks++; if (obs_br !== 1'b1) begin fails++; $display("[TB] FAIL rw_retry: got %b expected 1", obs_br); end
`endif
    checks++; if (b_rvalid !== 1'b1) begin fails++; $display("[TB] FAIL rw_rvalid: got %b expected 1", b_rvalid); end
    checks++; if (b_rdata !== 8'h33) begin fails++; $display("[TB] FAIL rw_data: got %h expected 33", b_rdata); end
    idle();
  endtask

  task automatic test_no_conflict();
    tick(1, 1, 4'h5, 8'h44, 0, 0, 4'h0, 8'h00);
    tick(1, 0, 4'h5, 8'h00, 1, 0, 4'h5, 8'h00);
    checks++; if ({obs_ar, obs_br} !== 2'b11) begin fails++; $display("[TB] FAIL rr_ready: got %b expected 11", {obs_ar, obs_br}); end
    checks++; if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== {2'b11, 16'h4444}) begin fails++; $display("[TB] FAIL rr_data: got %b %h %h expected 11 44 44", {a_rvalid, b_rvalid}, a_rdata, b_rdata); end
    tick(1, 1, 4'h0, 8'h01, 1, 1, 4'h1, 8'h02);
    checks++; if ({obs_ar, obs_br} !== 2'b11) begin fails++; $display("[TB] FAIL diff_ready: got %b expected 11", {obs_ar, obs_br}); end
    tick(1, 0, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00);
    checks++; if ({a_rdata, b_rdata} !== 16'h0102) begin fails++; $display("[TB] FAIL diff_mem: got %h %h expected 01 02", a_rdata, b_rdata); end
    idle();
  endtask

  task automatic test_reset_mid_read();
    tick(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
    checks++; if ({a_rvalid, a_rdata} !== {1'b1, 8'h5A}) begin fails++; $display("[TB] FAIL pre_rst_read: got %b %h expected 1 5a", a_rvalid, a_rdata); end
    reset = 1'b0;
    tick(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
    checks++; if (obs_ar !== 1'b0) begin fails++; $display("[TB] FAIL rst_ready: got %b expected 0", obs_ar); end
    checks++; if ({a_rvalid, a_rdata, conflict_cnt} !== 17'h0) begin fails++; $display("[TB] FAIL rst_clear: got %b %h %0d expected 0 00 0", a_rvalid, a_rdata, conflict_cnt); end
    reset = 1'b1;
    tick(1, 1, 4'h9, 8'h77, 1, 1, 4'h9, 8'h88);
    checks++; if ({obs_ar, obs_br} !== 2'b10) begin fails++; $display("[TB] FAIL rst_prio: got %b expected 10", {obs_ar, obs_br}); end
    checks++; if (conflict_cnt !== 8'd1) begin fails++; $display("[TB] FAIL rst_cnt: got %0d expected 1", conflict_cnt); end
    tick(0, 0, 4'h0, 8'h00, 1, 1, 4'h9, 8'h88);
    tick(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
    checks++; if ({a_rvalid, a_rdata} !== {1'b1, 8'h5A}) begin fails++; $display("[TB] FAIL rst_mem_kept: got %b %h expected 1 5a", a_rvalid, a_rdata); end
    idle();
  endtask

  // Reference model: memory array, the port owed priority, saturating counter.
  task automatic test_random();
    logic [7:0] mm [16];
    int         cnt_m;
    logic       fav_b;
    logic       ar, awe, br, bwe, a_hold, b_hold, conf, er_a, er_b, acc_a, acc_b;
    logic [3:0] aad, bad;
    logic [7:0] awd, bwd, exp_ad, exp_bd;
    reset = 1'b0;
    idle();
    reset = 1'b1;
    cnt_m = 0; fav_b = 1'b0; a_hold = 1'b0; b_hold = 1'b0;
    ar = 0; awe = 0; aad = 0; awd = 0; br = 0; bwe = 0; bad = 0; bwd = 0;
    for (int i = 0; i < 16; i++) begin
      mm[i] = 8'($urandom);
      tick(1, 1, 4'(i), mm[i], 0, 0, 4'h0, 8'h00);
    end
    for (int n = 0; n < 400; n++) begin
      if (!a_hold) begin
        ar = ($urandom_range(3) != 0); awe = 1'($urandom); aad = 4'($urandom_range(3)); awd = 8'($urandom);
      end
      if (!b_hold) begin
        br = ($urandom_range(3) != 0); bwe = 1'($urandom); bad = 4'($urandom_range(3)); bwd = 8'($urandom);
      end
`ifdef DPRAM_WRITE_FWD_EN
      conf = ar && br && (aad == bad) && awe && bwe;
`else
      conf = ar && br && (aad == bad) && (awe || bwe);
`endif
      er_a  = !conf || !fav_b;
      er_b  = !conf || fav_b;
      acc_a = ar && er_a;
      acc_b = br && er_b;
      exp_ad = (acc_b && bwe && bad == aad) ? bwd : mm[aad];
      exp_bd = (acc_a && awe && aad == bad) ? awd : mm[bad];
      tick(ar, awe, aad, awd, br, bwe, bad, bwd);
      checks++; if ({obs_ar, obs_br} !== {er_a, er_b}) begin fails++; $display("[TB] FAIL rnd_ready @%0d: got %b expected %b", n, {obs_ar, obs_br}, {er_a, er_b}); end
      checks++; if ({a_rvalid, b_rvalid} !== {acc_a && !awe, acc_b && !bwe}) begin fails++; $display("[TB] FAIL rnd_rvalid @%0d: got %b expected %b", n, {a_rvalid, b_rvalid}, {acc_a && !awe, acc_b && !bwe}); end
      if (acc_a && !awe) begin
        checks++; if (a_rdata !== exp_ad) begin fails++; $display("[TB] FAIL rnd_a_rdata @%0d: got %h expected %h", n, a_rdata, exp_ad); end
      end
      if (acc_b && !bwe) begin
        checks++; if (b_rdata !== exp_bd) begin fails++; $display("[TB] FAIL rnd_b_rdata @%0d: got %h expected %h", n, b_rdata, exp_bd); end
      end
      if (acc_a && awe) mm[aad] = awd;
      if (acc_b && bwe) mm[bad] = bwd;
      if (conf) begin
        fav_b = !er_b;
        if (cnt_m < 255) cnt_m++;
      end
      checks++; if (conflict_cnt !== 8'(cnt_m)) begin fails++; $display("[TB] FAIL rnd_cnt @%0d: got %0d expected %0d", n, conflict_cnt, cnt_m); end
      a_hold = ar && !er_a;
      b_hold = br && !er_b;
    end
    idle();
  endtask

  task automatic test_saturation();
    reset = 1'b0;
    idle();
    reset = 1'b1;
    for (int i = 0; i < 254; i++) tick(1, 1, 4'hA, 8'hA0, 1, 1, 4'hA, 8'hB0);
    checks++; if (conflict_cnt !== 8'd254) begin fails++; $display("[TB] FAIL sat_below: got %0d expected 254", conflict_cnt); end
    for (int i = 0; i < 5; i++) tick(1, 1, 4'hA, 8'hA0, 1, 1, 4'hA, 8'hB0);
    checks++; if (conflict_cnt !== 8'd255) begin fails++; $display("[TB] FAIL sat_max: got %0d expected 255", conflict_cnt); end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    test_reset();
    test_write_read();
    test_ww_conflict();
    test_rw_conflict();
    test_no_conflict();
    test_reset_mid_read();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
